l1_l2_arbiter: RTL

//  Shares the single L2$ request/response port between the I$ and the D$ miss/writeback paths.

---
 rtl/l1_l2_arbiter_if.sv | 55 +++++
 rtl/l1_l2_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter_if.sv
// Request/response bundle between the I$/D$ refill paths, the L1-L2 arbiter and the L2$ port.
// The slave modport is the arbiter's view; master is the caches-plus-L2 environment.
interface l1_l2_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 64
);
    localparam int LINE_BITS = LINE_SIZE * 8;

    logic                  ic_req_valid_i;
    logic [ADDR_WIDTH-1:0] ic_req_addr_i;
    logic                  ic_req_ready_o;
    logic                  ic_resp_valid_o;
    logic [LINE_BITS-1:0]  ic_resp_data_o;
    logic                  ic_resp_ready_i;

    logic                  dc_req_valid_i;
    logic [ADDR_WIDTH-1:0] dc_req_addr_i;
    logic                  dc_req_we_i;
    logic [LINE_BITS-1:0]  dc_req_wdata_i;
    logic                  dc_req_ready_o;
    logic                  dc_resp_valid_o;
    logic [LINE_BITS-1:0]  dc_resp_data_o;
    logic                  dc_resp_ready_i;

    logic                  l2_req_valid_o;
    logic [ADDR_WIDTH-1:0] l2_req_addr_o;
    logic                  l2_req_we_o;
    logic [LINE_BITS-1:0]  l2_req_wdata_o;
    logic                  l2_req_ready_i;
    logic                  l2_resp_valid_i;
    logic [LINE_BITS-1:0]  l2_resp_data_i;
    logic                  l2_resp_ready_o;

    logic                  busy_o;

    modport slave (
        input  ic_req_valid_i, ic_req_addr_i, ic_resp_ready_i,
        input  dc_req_valid_i, dc_req_addr_i, dc_req_we_i, dc_req_wdata_i, dc_resp_ready_i,
        input  l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i,
        output ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
        output dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
        output l2_req_valid_o, l2_req_addr_o, l2_req_we_o, l2_req_wdata_o, l2_resp_ready_o,
        output busy_o
    );

    modport master (
        output ic_req_valid_i, ic_req_addr_i, ic_resp_ready_i,
        output dc_req_valid_i, dc_req_addr_i, dc_req_we_i, dc_req_wdata_i, dc_resp_ready_i,
        output l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i,
        input  ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o,
        input  dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
        input  l2_req_valid_o, l2_req_addr_o, l2_req_we_o, l2_req_wdata_o, l2_resp_ready_o,
        input  busy_o
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2$ port between I$ fills and D$ fills/writebacks.
// One line-sized transaction in flight at a time; the response returns to whoever was granted.
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    l1_l2_arbiter_if.slave     bus
);
    localparam int LINE_BITS = LINE_SIZE * 8;
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_SIZE - 1);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT, DELIVER} state_e;
    typedef enum logic {SRC_IC, SRC_DC} src_e;

    state_e                state_q;
    src_e                  last_grant_q;
    src_e                  id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [LINE_BITS-1:0]  data_q;
    logic                  l2_req_valid_q;
    logic                  l2_resp_ready_q;
    logic                  ic_resp_valid_q;
    logic                  dc_resp_valid_q;
    logic                  busy_q;

    logic arb_open;
    logic gnt_ic;
    logic gnt_dc;
    logic resp_taken;

    // NOTE: grants are combinational so the requester sees ready in its own cycle; gating with
    // rst_i keeps every output low while reset is held, even though ARB is the reset state.
    assign arb_open   = (state_q == ARB) && !rst_i;
    assign gnt_ic     = arb_open && bus.ic_req_valid_i &&
                        (!bus.dc_req_valid_i || last_grant_q == SRC_DC);
    assign gnt_dc     = arb_open && bus.dc_req_valid_i &&
                        (!bus.ic_req_valid_i || last_grant_q == SRC_IC);
    assign resp_taken = (id_q == SRC_IC) ? bus.ic_resp_ready_i : bus.dc_resp_ready_i;

    // NOTE: the line-wide registers are plain flops, not a memory, so clearing them on reset is cheap
    // and guarantees zero outputs straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ARB;
            last_grant_q    <= SRC_DC;
            id_q            <= SRC_IC;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            data_q          <= '0;
            l2_req_valid_q  <= 1'b0;
            l2_resp_ready_q <= 1'b0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (gnt_ic) begin
                        id_q           <= SRC_IC;
                        last_grant_q   <= SRC_IC;
                        addr_q         <= bus.ic_req_addr_i & ~OFFSET_MASK;
                        we_q           <= 1'b0;
                        wdata_q        <= '0;
                        l2_req_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ISSUE;
                    end else if (gnt_dc) begin
                        id_q           <= SRC_DC;
                        last_grant_q   <= SRC_DC;
                        addr_q         <= bus.dc_req_addr_i & ~OFFSET_MASK;
                        we_q           <= bus.dc_req_we_i;
                        wdata_q        <= bus.dc_req_wdata_i;
                        l2_req_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.l2_req_ready_i) begin
                        l2_req_valid_q  <= 1'b0;
                        l2_resp_ready_q <= 1'b1;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.l2_resp_valid_i) begin
                        data_q          <= we_q ? '0 : bus.l2_resp_data_i;
                        l2_resp_ready_q <= 1'b0;
                        ic_resp_valid_q <= (id_q == SRC_IC);
                        dc_resp_valid_q <= (id_q == SRC_DC);
                        state_q         <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (resp_taken) begin
                        ic_resp_valid_q <= 1'b0;
                        dc_resp_valid_q <= 1'b0;
                        busy_q          <= 1'b0;
                        state_q         <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.ic_req_ready_o  = gnt_ic;
    assign bus.dc_req_ready_o  = gnt_dc;
    assign bus.ic_resp_valid_o = ic_resp_valid_q;
    assign bus.dc_resp_valid_o = dc_resp_valid_q;
    assign bus.ic_resp_data_o  = (id_q == SRC_IC) ? data_q : '0;
    assign bus.dc_resp_data_o  = (id_q == SRC_DC) ? data_q : '0;
    assign bus.l2_req_valid_o  = l2_req_valid_q;
    assign bus.l2_req_addr_o   = addr_q;
    assign bus.l2_req_we_o     = we_q;
    assign bus.l2_req_wdata_o  = wdata_q;
    assign bus.l2_resp_ready_o = l2_resp_ready_q;
    assign bus.busy_o          = busy_q;
endmodule
